// File: rtl/sap1_prog_loader.sv
// SAP-1 boot loader: streams program words into the 16x8 RAM,
// zero-fills the remainder, then releases the CPU from reset.
module sap1_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              cpu_halt,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   prog_len,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FILL   = 3'd2,
        RUN    = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W:0]   len_n;
    logic              we_n, rdy_n, crst_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              accept;
    logic              running, running_n;

    assign accept    = in_valid & in_ready;
    assign state_o   = state;
    assign running   = (state == RUN) || (state == HALTED);
    assign running_n = (state_n == RUN) || (state_n == HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            prog_len  <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            in_ready  <= 1'b0;
            cpu_rst   <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            prog_len  <= len_n;
            ram_we    <= we_n;
            ram_addr  <= addr_n;
            ram_wdata <= wdata_n;
            in_ready  <= rdy_n;
            cpu_rst   <= crst_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = prog_len;
        we_n    = 1'b0;
        addr_n  = ram_addr;
        wdata_n = ram_wdata;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                    len_n   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    we_n    = 1'b1;
                    addr_n  = cnt;
                    wdata_n = in_data;
                    len_n   = prog_len + 1'b1;
                    // Last slot ends the load; counter parks instead of wrapping
                    if (cnt == LAST) begin
                        state_n = RUN;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (in_last) state_n = FILL;
                    end
                end
            end
            FILL: begin
                we_n    = 1'b1;
                addr_n  = cnt;
                wdata_n = '0;
                if (cnt == LAST) state_n = RUN;
                else             cnt_n   = cnt + 1'b1;
            end
            RUN, HALTED: begin
                if (start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                    len_n   = '0;
                end else if (cpu_halt) begin
                    state_n = HALTED;
                end
            end
            default: state_n = IDLE;
        endcase
        rdy_n  = (state_n == LOAD);
        // Release reset one edge after entering RUN, once the last write is out
        crst_n = !(running && running_n);
    end

endmodule
